trigger_conditioner: RTL

//  Turns the raw, asynchronous, bouncy gun-trigger input into clean single-cycle shot pulses.

---
 rtl/trigger_conditioner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/trigger_conditioner.sv
// trigger_conditioner
// Converts the raw, bouncy, asynchronous gun trigger into clean single-cycle
// shot pulses for the shot keeper. Firing is allowed only in the play state.
// An empty magazine turns a press into a dry_fire click instead of a shot.
// After each shot there is a refire cooldown, and the trigger must be
// released before it can fire again. The cursor position is latched as each
// shot is taken.
// Output timing: every output is a flop fed from the current FSM state.
// shot and busy therefore lag the FSM state by one cycle. dry_fire and the
// shot_x/shot_y capture are registered on the edge the FSM takes the
// corresponding ARMED decision.
module trigger_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         COOLDOWN_CYCLES = 12500000,
  parameter logic [2:0] PLAY_STATE      = 3'd2,
  parameter int         COORD_W         = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               trigger_raw,
  input  logic [2:0]         state,
  input  logic               no_shots_left,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  output logic               shot,
  output logic               dry_fire,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               busy
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ?
                              DEBOUNCE_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FIRE,
    COOLDOWN,
    RELEASE
  } fsm_t;

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic             sync1;
  logic             sync2;
  logic             trig_stable;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] cd_cnt;
  logic             in_play;
  logic             shot_d;
  logic             dry_fire_d;
  logic             busy_d;
  logic             load_pos;

  assign in_play = (state == PLAY_STATE);

  // Two-flop synchronizer for the asynchronous trigger input.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse sync1/sync2.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= trigger_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      trig_stable <= 1'b0;
      deb_cnt     <= '0;
    end else if (sync2 == trig_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt >= DEB_LAST) begin
      trig_stable <= sync2;
      deb_cnt     <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_ONE;
    end
  end

  // Cooldown counter: runs only in COOLDOWN, cleared elsewhere, saturates at its terminal value.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cd_cnt <= '0;
    end else if (fsm_q == COOLDOWN) begin
      if (cd_cnt != CD_LAST) begin
        cd_cnt <= cd_cnt + CNT_ONE;
      end
    end else begin
      cd_cnt <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic.
  // NOTE: fsm_d gets a default before the case so every path assigns it;
  // a missing assignment in always_comb would infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (in_play && !trig_stable) fsm_d = ARMED;
      end
      ARMED: begin
        if (!in_play)                           fsm_d = IDLE;
        else if (trig_stable && !no_shots_left) fsm_d = FIRE;
        else if (trig_stable)                   fsm_d = RELEASE;
      end
      FIRE: begin
        fsm_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (!in_play)               fsm_d = IDLE;
        else if (cd_cnt == CD_LAST) fsm_d = RELEASE;
      end
      RELEASE: begin
        if (!in_play)         fsm_d = IDLE;
        else if (!trig_stable) fsm_d = ARMED;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // FSM output decode, fed to the output flops below.
  always_comb begin
    shot_d     = (fsm_q == FIRE);
    busy_d     = (fsm_q == FIRE) || (fsm_q == COOLDOWN);
    dry_fire_d = (fsm_q == ARMED) && (fsm_d == RELEASE);
    load_pos   = (fsm_q == ARMED) && (fsm_d == FIRE);
  end

  // Registered outputs; the cursor is captured on the edge that enters FIRE.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      shot     <= 1'b0;
      dry_fire <= 1'b0;
      busy     <= 1'b0;
      shot_x   <= '0;
      shot_y   <= '0;
    end else begin
      shot     <= shot_d;
      dry_fire <= dry_fire_d;
      busy     <= busy_d;
      if (load_pos) begin
        shot_x <= cursor_x;
        shot_y <= cursor_y;
      end
    end
  end

endmodule
